// File: rtl/vend_pkg.sv
// Shared constants for the vending sequencer: state codes, selection range, price table.
package vend_pkg;

  // FSM state encoding, also driven out on the debug/LED port
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCollect = 3'd1;
  localparam logic [2:0] StVend    = 3'd2;
  localparam logic [2:0] StChange  = 3'd3;

  localparam logic [2:0] SEL_MIN = 3'd1;
  localparam logic [2:0] SEL_MAX = 3'd5;

  localparam int unsigned PRICE_W = 4;

  // Price in coin units for a drink selection; 0 for an invalid selection
  function automatic logic [PRICE_W-1:0] sel_price(input logic [2:0] s);
    logic [PRICE_W-1:0] p;
    case (s)
      3'd1:    p = 4'd2;
      3'd2:    p = 4'd3;
      3'd3:    p = 4'd4;
      3'd4:    p = 4'd5;
      3'd5:    p = 4'd6;
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  function automatic logic sel_valid(input logic [2:0] s);
    return (s >= SEL_MIN) && (s <= SEL_MAX);
  endfunction

endpackage

// File: rtl/vend_credit_reg.sv
// Credit register: add with overflow check, subtract clamped at zero.
module vend_credit_reg #(
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                add_en_i,
  input  logic [1:0]          add_val_i,
  input  logic                sub_en_i,
  input  logic [CREDIT_W-1:0] sub_val_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                ovf_o
);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W:0]   sum;

  // Overflow flag is combinational so the controller can reject in the same cycle
  always_comb begin
    sum   = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, add_val_i};
    ovf_o = sum[CREDIT_W];
  end

  // Next credit: an overflowing add is dropped entirely; subtraction never wraps
  always_comb begin
    credit_d = credit_q;
    if (add_en_i && !ovf_o) begin
      credit_d = sum[CREDIT_W-1:0];
    end else if (sub_en_i) begin
      credit_d = (sub_val_i > credit_q) ? '0 : credit_q - sub_val_i;
    end
  end

  // Credit state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) credit_q <= '0;
    else         credit_q <= credit_d;
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine controller: coin collection, price check, vend and change handshakes.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                M1,
  input  logic                M2,
  input  logic [2:0]          sel,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                coin_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_req,
  output logic [2:0]          bebida,
  output logic                change_req,
  output logic                coin_reject,
  output logic                to,
  output logic [2:0]          state
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [2:0]          state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vend_req_q, vend_req_d;
  logic [2:0]          bebida_q, bebida_d;
  logic                change_req_q, change_req_d;
  logic                coin_reject_q, coin_reject_d;
  logic                to_q, to_d;

  logic [CREDIT_W-1:0] credit_q;
  logic                ovf;
  logic                add_en, sub_en;
  logic [1:0]          coin_val;
  logic [CREDIT_W-1:0] sub_val;
  logic                coin_in, take;
  logic [PRICE_W-1:0]  new_price, vend_price;

  vend_credit_reg #(
    .CREDIT_W (CREDIT_W)
  ) u_credit (
    .clk_i     (clk),
    .rst_ni    (rst),
    .add_en_i  (add_en),
    .add_val_i (coin_val),
    .sub_en_i  (sub_en),
    .sub_val_i (sub_val),
    .credit_o  (credit_q),
    .ovf_o     (ovf)
  );

  // Coin decode and acceptance; coins only count while collecting
  always_comb begin
    coin_val      = {1'b0, M1} + {M2, 1'b0};
    coin_in       = M1 | M2;
    take          = coin_in && !ovf && ((state_q == StIdle) || (state_q == StCollect));
    add_en        = take;
    coin_reject_d = coin_in && !take;
    new_price     = sel_price(sel);
    vend_price    = sel_price(sel_q);
  end

  // Next-state logic; price check uses the pre-add credit
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = '0;
    to_d    = 1'b0;
    sub_en  = 1'b0;
    sub_val = '0;
    case (state_q)
      StIdle: begin
        if (take) state_d = StCollect;
      end
      StCollect: begin
        cnt_d = take ? '0 : cnt_q + CNT_W'(1);
        if (cancel) begin
          state_d = StChange;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = StChange;
          to_d    = 1'b1;
        end else if (sel_valid(sel) && (32'(credit_q) >= 32'(new_price))) begin
          state_d = StVend;
          sel_d   = sel;
        end
        if (state_d != StCollect) cnt_d = '0;
      end
      StVend: begin
        if (vend_ack) begin
          sub_en  = 1'b1;
          sub_val = CREDIT_W'(vend_price);
          state_d = (32'(credit_q) > 32'(vend_price)) ? StChange : StIdle;
        end
      end
      StChange: begin
        if (credit_q == '0) begin
          state_d = StIdle;
        end else if (coin_ack) begin
          sub_en  = 1'b1;
          sub_val = CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    vend_req_d   = (state_d == StVend);
    bebida_d     = (state_d == StVend) ? sel_d : 3'd0;
    change_req_d = (state_d == StChange);
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      sel_q         <= 3'd0;
      cnt_q         <= '0;
      vend_req_q    <= 1'b0;
      bebida_q      <= 3'd0;
      change_req_q  <= 1'b0;
      coin_reject_q <= 1'b0;
      to_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      vend_req_q    <= vend_req_d;
      bebida_q      <= bebida_d;
      change_req_q  <= change_req_d;
      coin_reject_q <= coin_reject_d;
      to_q          <= to_d;
    end
  end

  assign credit      = credit_q;
  assign vend_req    = vend_req_q;
  assign bebida      = bebida_q;
  assign change_req  = change_req_q;
  assign coin_reject = coin_reject_q;
  assign to          = to_q;
  assign state       = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed vector table, corner sequences, random run.
module tb_vend_sequencer;

  localparam int CW   = 4;
  localparam int TO   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          M1 = 0, M2 = 0, cancel = 0, vend_ack = 0, coin_ack = 0;
  logic [2:0]    sel = 3'd0;
  logic [CW-1:0] credit;
  logic          vend_req, change_req, coin_reject, to;
  logic [2:0]    bebida, state;

  vend_sequencer #(
    .CREDIT_W    (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .M1          (M1),
    .M2          (M2),
    .sel         (sel),
    .cancel      (cancel),
    .vend_ack    (vend_ack),
    .coin_ack    (coin_ack),
    .credit      (credit),
    .vend_req    (vend_req),
    .bebida      (bebida),
    .change_req  (change_req),
    .coin_reject (coin_reject),
    .to          (to),
    .state       (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integers, state numbers 0=idle 1=collect 2=vend 3=change
  int price_tab [8] = '{0, 2, 3, 4, 5, 6, 0, 0};
  int ms = 0, mc = 0, mcnt = 0, msel = 0, m_rej = 0, m_to = 0;

  task automatic model_reset();
    ms = 0; mc = 0; mcnt = 0; msel = 0; m_rej = 0; m_to = 0;
  endtask

  task automatic model_step(input bit m1, input bit m2, input int s, input bit cn,
                            input bit va, input bit ca);
    int  v;
    int  old_c;
    int  old_s;
    bit  take;
    v     = int'(m1) + 2 * int'(m2);
    old_c = mc;
    old_s = ms;
    take  = (v != 0) && (ms <= 1) && (mc + v <= MAXC);
    m_rej = ((v != 0) && !take) ? 1 : 0;
    m_to  = 0;
    if (take) mc = mc + v;
    case (old_s)
      0: if (take) begin ms = 1; mcnt = 0; end
      1: begin
        if (cn) ms = 3;
        else if (mcnt == TO - 1) begin ms = 3; m_to = 1; end
        else if (s >= 1 && s <= 5 && old_c >= price_tab[s]) begin ms = 2; msel = s; end
        if (ms != 1) mcnt = 0;
        else mcnt = take ? 0 : mcnt + 1;
      end
      2: if (va) begin
        mc = mc - price_tab[msel];
        ms = (mc > 0) ? 3 : 0;
      end
      3: if (mc == 0) ms = 0;
         else if (ca) begin
           mc = mc - 1;
           if (mc == 0) ms = 0;
         end
      default: ms = 0;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("mdl_state", int'(state), ms);
    chk("mdl_credit", int'(credit), mc);
    chk("mdl_vend_req", int'(vend_req), (ms == 2) ? 1 : 0);
    chk("mdl_bebida", int'(bebida), (ms == 2) ? msel : 0);
    chk("mdl_change_req", int'(change_req), (ms == 3) ? 1 : 0);
    chk("mdl_coin_reject", int'(coin_reject), m_rej);
    chk("mdl_to", int'(to), m_to);
  endtask

  // One clock: drive on negedge, model at posedge, sample 1 ns later
  task automatic step(input bit m1, input bit m2, input int s, input bit cn, input bit va,
                      input bit ca);
    @(negedge clk);
    M1 = m1; M2 = m2; sel = 3'(s); cancel = cn; vend_ack = va; coin_ack = ca;
    @(posedge clk);
    model_step(m1, m2, s, cn, va, ca);
    #1;
    check_model();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit m1, m2; int s; bit cn, va, ca;
    int st, cr, vr, bb, cq, rj;
  } vec_t;

  function automatic vec_t mk(bit m1, bit m2, int s, bit cn, bit va, bit ca,
                              int st, int cr, int vr, int bb, int cq, int rj);
    vec_t v;
    v.m1 = m1; v.m2 = m2; v.s = s; v.cn = cn; v.va = va; v.ca = ca;
    v.st = st; v.cr = cr; v.vr = vr; v.bb = bb; v.cq = cq; v.rj = rj;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table: m1 m2 sel cn va ca | state credit vreq bebida creq rej
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 4, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2, 0, 0, 0,  2, 5, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  2, 5, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  3, 2, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  3, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  2, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 3, 0, 0, 0,  1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0,  1, 4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0, 0,  2, 4, 1, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2, 4, 1, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_outs", int'({vend_req, bebida, change_req, coin_reject, to}), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      step(vecs[i].m1, vecs[i].m2, vecs[i].s, vecs[i].cn, vecs[i].va, vecs[i].ca);
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
      chk($sformatf("vec%0d_credit", i), int'(credit), vecs[i].cr);
      chk($sformatf("vec%0d_vend_req", i), int'(vend_req), vecs[i].vr);
      chk($sformatf("vec%0d_bebida", i), int'(bebida), vecs[i].bb);
      chk($sformatf("vec%0d_change_req", i), int'(change_req), vecs[i].cq);
      chk($sformatf("vec%0d_coin_reject", i), int'(coin_reject), vecs[i].rj);
    end

    // Timeout: one coin then TO silent cycles
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      idle();
      chk("tmo_wait_state", int'(state), 1);
      chk("tmo_wait_to", int'(to), 0);
    end
    idle();
    chk("tmo_state", int'(state), 3);
    chk("tmo_to", int'(to), 1);
    chk("tmo_change_req", int'(change_req), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("tmo_to_clear", int'(to), 0);
    chk("tmo_done_state", int'(state), 0);
    chk("tmo_done_credit", int'(credit), 0);

    // Overflow: credit 14, reject M2, accept M1, reject M1+M2 at full credit
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0);
    chk("ovf_pre_credit", int'(credit), 14);
    step(0, 1, 0, 0, 0, 0);
    chk("ovf_reject", int'(coin_reject), 1);
    chk("ovf_hold_credit", int'(credit), 14);
    step(1, 0, 0, 0, 0, 0);
    chk("ovf_m1_reject", int'(coin_reject), 0);
    chk("ovf_m1_credit", int'(credit), 15);
    step(1, 1, 0, 0, 0, 0);
    chk("ovf_full_reject", int'(coin_reject), 1);
    chk("ovf_full_credit", int'(credit), 15);
    step(0, 0, 0, 1, 0, 0);
    chk("ovf_cancel_state", int'(state), 3);
    begin
      int budget;
      budget = 40;
      while (state != 3'd0 && budget > 0) begin
        step(0, 0, 0, 0, 0, 1);
        budget--;
      end
      chk("ovf_refund_done", int'(state), 0);
      chk("ovf_refund_credit", int'(credit), 0);
    end

    // Cancel beats a valid, affordable selection
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("cansel_state", int'(state), 3);
    chk("cansel_vend_req", int'(vend_req), 0);
    chk("cansel_change_req", int'(change_req), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("cansel_done", int'(state), 0);

    // Async reset while vend_req is high
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("arst_pre_vreq", int'(vend_req), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_credit", int'(credit), 0);
    chk("arst_outs", int'({vend_req, bebida, change_req, coin_reject, to}), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle();
    chk("arst_after_state", int'(state), 0);

    // Random traffic in segments of differing coin density
    for (int seg = 0; seg < 15; seg++) begin
      int pct;
      case (seg % 4)
        0: pct = 4;
        1: pct = 20;
        2: pct = 40;
        default: pct = 70;
      endcase
      for (int c = 0; c < 200; c++) begin
        step($urandom_range(99) < pct, $urandom_range(99) < pct, int'($urandom_range(7)),
             $urandom_range(99) < 3, $urandom_range(99) < 40, $urandom_range(99) < 50);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Top-level control FSM for the vending machine datapath. It accumulates coin credit, checks the drink selection against a fixed price table, and runs a vend request/acknowledge handshake with the dispenser. It then returns change one unit coin at a time through a second handshake. It replaces the free-running coin counter, register and comparator chain with one sequenced controller that owns the credit register.

Parameters:
CREDIT_W, 4, width of credit register in coin units (max credit 2**CREDIT_W-1)
TIMEOUT_CYC, 16, idle cycles in COLLECT before automatic refund (must be >=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
M1  input  1  one-cycle pulse: 1-unit coin inserted
M2  input  1  one-cycle pulse: 2-unit coin inserted
sel  input  3  drink selection; 1..5 valid, 0/6/7 = no selection
cancel  input  1  user refund request (level, sampled each cycle)
vend_ack  input  1  dispenser accepted drink
coin_ack  input  1  change hopper released one 1-unit coin
credit  output  CREDIT_W  current credit (registered)
vend_req  output  1  drink dispense request
bebida  output  3  latched selection while vend_req is high, else 0
change_req  output  1  request one 1-unit coin from hopper
coin_reject  output  1  one-cycle pulse: inserted coin not accepted
to  output  1  one-cycle pulse: timeout refund started
state  output  3  encoded FSM state, for debug/LEDs

Behaviour:
- Reset (rst=0, async): state=IDLE; credit=0; vend_req=0; bebida=0; change_req=0; coin_reject=0; to=0; idle counter=0.
- All outputs are registered; a decision made on cycle N is visible on cycle N+1.
- Coin value per cycle: M1 + 2*M2 (both high = 3).
- Coin acceptance:
  - Accepted in IDLE and COLLECT only. Credit += value.
  - If credit + value would exceed 2**CREDIT_W-1, the whole value is rejected, credit is unchanged and coin_reject pulses.
  - Any coin in VEND or CHANGE is rejected the same way.
- Price table (package constant): sel 1->2, 2->3, 3->4, 4->5, 5->6 units.
- States:
  - IDLE (0): accepted coin -> COLLECT. sel is ignored while credit=0.
  - COLLECT (1):
    - Idle counter clears on every accepted coin and increments otherwise.
    - Priority 1: cancel=1 -> CHANGE (refund).
    - Priority 2: counter reaches TIMEOUT_CYC-1 -> CHANGE, with to pulsing 1 cycle.
    - Priority 3: valid sel with registered credit >= price -> latch sel, go to VEND.
    - A coin arriving in the same cycle as a valid sel is still added. The comparison uses the pre-add credit.
    - Valid sel with insufficient credit: no action, stay in COLLECT.
  - VEND (2):
    - vend_req=1 and bebida=latched sel, both held stable until vend_ack.
    - On vend_ack: credit -= price; vend_req drops next cycle. Next state is CHANGE if the resulting credit > 0, else IDLE.
    - cancel is ignored in VEND.
  - CHANGE (3):
    - change_req=1 while credit > 0.
    - Each cycle with coin_ack=1: credit -= 1.
    - When credit becomes 0: change_req=0, go to IDLE.
    - coin_ack with credit=0 is ignored. credit never underflows.
- Idle counter resets on entry to COLLECT and holds 0 outside COLLECT.
- Reset mid-handshake aborts immediately. Credit is lost by design; no state is retained.
- vend_ack and coin_ack outside their states are ignored.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, COLLECT, VEND, CHANGE, 3-bit encoding)
  - price lookup function / constant array indexed by sel
  - SEL_MIN=1, SEL_MAX=5
- One sub-module is natural: vend_credit_reg. It is a CREDIT_W saturating-check add/subtract register with add_val, sub_val and overflow flag; the FSM drives its controls.
- The idle-timeout counter stays inline.

Test Plan:
- Coins M2, M2, M1 (credit 5), sel=2 -> VEND with bebida=2, vend_req held; vend_ack -> credit 2; two coin_ack -> credit 0, IDLE; change_req total 2 cycles.
- Exact payment: M2 then sel=1 -> vend_ack leaves credit 0, goes directly to IDLE with no change_req.
- Insufficient credit: M1 then sel=3 held 5 cycles -> stays in COLLECT, vend_req=0. Add M1+M2 in the same cycle -> credit 4, next cycle VEND.
- Overflow: credit 14, then M2 -> coin_reject pulse, credit stays 14. Then M1 -> credit 15.
- Timeout: M1 then no activity for TIMEOUT_CYC cycles -> to pulses once, CHANGE, one coin_ack -> IDLE. cancel and valid sel together -> refund path wins.
- Async reset asserted while vend_req=1 -> all outputs 0 immediately, IDLE after release; coin inserted during VEND -> coin_reject, credit unchanged.
